// File: rtl/pulse_train.sv
// Programmable burst pulse generator: emits num pulses of period clocks each,
// with out high for the first high clocks of every period.
module pulse_train #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          start,
  input  logic          stop,
  input  logic [DW-1:0] period,
  input  logic [DW-1:0] high,
  input  logic [DW-1:0] num,
  output logic          out,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] remaining,
  output logic [1:0]    dbg_state_o
);

  // Handshake: start is taken only in IDLE (stop has priority); busy is high for
  // every RUN cycle; done is a single-cycle pulse after a normal finish; stop in
  // RUN aborts with no done pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] period_q, period_d;
  logic [DW-1:0] high_q, high_d;
  logic [DW-1:0] num_q, num_d;
  logic [DW-1:0] phase_q, phase_d;
  logic [DW-1:0] remaining_q, remaining_d;
  logic          out_q, out_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] p_last;
  logic [DW-1:0] phase_inc;

  // period=0 behaves as period=1, so both wrap at phase 0.
  assign p_last    = (period_q == '0) ? '0 : period_q - DW'(1);
  assign phase_inc = phase_q + DW'(1);

  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    high_d      = high_q;
    num_d       = num_q;
    phase_d     = phase_q;
    remaining_d = remaining_q;
    out_d       = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          period_d    = period;
          high_d      = high;
          num_d       = num;
          phase_d     = '0;
          remaining_d = num;
          state_d     = RUN;
          busy_d      = 1'b1;
          out_d       = (high != '0);
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          phase_d = '0;
        end else if (phase_q == p_last) begin
          phase_d = '0;
          busy_d  = 1'b1;
          out_d   = (high_q != '0);
          if (num_q != '0) begin
            remaining_d = remaining_q - DW'(1);
            if (remaining_q == DW'(1)) begin
              state_d = DONE;
              busy_d  = 1'b0;
              out_d   = 1'b0;
              done_d  = 1'b1;
            end
          end
        end else begin
          phase_d = phase_inc;
          busy_d  = 1'b1;
          out_d   = (phase_inc < high_q);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      period_q    <= '0;
      high_q      <= '0;
      num_q       <= '0;
      phase_q     <= '0;
      remaining_q <= '0;
      out_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      high_q      <= high_d;
      num_q       <= num_d;
      phase_q     <= phase_d;
      remaining_q <= remaining_d;
      out_q       <= out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out         = out_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign remaining   = remaining_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pulse_train.sv
// Bench for pulse_train: directed scenarios plus randomized bursts checked
// against an arithmetic model of the pulse train.
module tb_pulse_train;

  logic        clk;
  logic        nreset;
  logic        start;
  logic        stop;
  logic [15:0] period;
  logic [15:0] high;
  logic [15:0] num;
  logic        out;
  logic        busy;
  logic        done;
  logic [15:0] remaining;
  logic [1:0]  dbg_state;

  int total;
  int bad;
  logic [18:0] exp_q[$];

  pulse_train #(.DW(16)) dut (
    .clk         (clk),
    .nreset      (nreset),
    .start       (start),
    .stop        (stop),
    .period      (period),
    .high        (high),
    .num         (num),
    .out         (out),
    .busy        (busy),
    .done        (done),
    .remaining   (remaining),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [18:0] pack(input logic o, input logic b, input logic d,
                                       input logic [15:0] r);
    return {o, b, d, r};
  endfunction

  task automatic test_reset();
    nreset = 1'b0; start = 1'b0; stop = 1'b0;
    period = 16'd0; high = 16'd0; num = 16'd0;
    repeat (3) tick();
    total++;
    if ({out, busy, done, remaining} !== pack(0, 0, 0, 16'd0)) begin
      bad++;
      $display("FAIL reset_hold got=%h exp=%h", {out, busy, done, remaining}, pack(0, 0, 0, 16'd0));
    end
    @(negedge clk);
    nreset = 1'b1;
    repeat (4) begin
      tick();
      total++;
      if ({out, busy, done, remaining} !== pack(0, 0, 0, 16'd0)) begin
        bad++;
        $display("FAIL reset_release_idle got=%h exp=%h", {out, busy, done, remaining}, pack(0, 0, 0, 16'd0));
      end
    end
  endtask

  // Runs a full burst; model: RUN cycle k has phase k%P, out=(phase<high),
  // remaining=num-k/P; then one done cycle with everything low.
  task automatic run_burst(input logic [15:0] per, input logic [15:0] hi,
                           input logic [15:0] n, input bit noise, input string name);
    int p;
    int len;
    logic [18:0] exp_v;
    p   = (per == 16'd0) ? 1 : int'(per);
    len = int'(n) * p;
    for (int k = 0; k < len; k++)
      exp_q.push_back(pack((k % p) < int'(hi), 1'b1, 1'b0, 16'(int'(n) - k / p)));
    exp_q.push_back(pack(0, 0, 1, 16'd0));
    period = per; high = hi; num = n; start = 1'b1; stop = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k <= len; k++) begin
      exp_v = exp_q.pop_front();
      total++;
      if ({out, busy, done, remaining} !== exp_v) begin
        bad++;
        $display("FAIL %s cyc=%0d got=%h exp=%h", name, k + 1, {out, busy, done, remaining}, exp_v);
      end
      if (noise) begin
        start  = 1'($urandom_range(0, 1));
        period = 16'($urandom);
        high   = 16'($urandom);
        num    = 16'($urandom);
      end
      tick();
    end
    // a start seen during the done cycle must be ignored
    start = 1'b0;
    total++;
    if ({out, busy, done} !== 3'b000) begin
      bad++;
      $display("FAIL %s after_done got=%b exp=000", name, {out, busy, done});
    end
  endtask

  task automatic test_basic();
    logic [11:0] pat;
    int rem_tab[12];
    pat = 12'b110011001100;
    rem_tab = '{3, 3, 3, 3, 2, 2, 2, 2, 1, 1, 1, 1};
    period = 16'd4; high = 16'd2; num = 16'd3; start = 1'b1; stop = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      total++;
      if ({out, busy, done, remaining} !== pack(pat[11-k], 1, 0, 16'(rem_tab[k]))) begin
        bad++;
        $display("FAIL basic cyc=%0d got=%h exp=%h", k + 1, {out, busy, done, remaining},
                 pack(pat[11-k], 1, 0, 16'(rem_tab[k])));
      end
      tick();
    end
    total++;
    if ({out, busy, done} !== 3'b001) begin
      bad++;
      $display("FAIL basic_done got=%b exp=001", {out, busy, done});
    end
    tick();
    total++;
    if ({out, busy, done} !== 3'b000) begin
      bad++;
      $display("FAIL basic_idle got=%b exp=000", {out, busy, done});
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if ({out, busy, remaining} !== {1'b1, 1'b1, 16'd3}) begin
      bad++;
      $display("FAIL basic_restart got=%h exp=%h", {out, busy, remaining}, {1'b1, 1'b1, 16'd3});
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_clamps();
    run_burst(16'd0, 16'd1, 16'd5, 1'b0, "clamp_p0");
    run_burst(16'd3, 16'd7, 16'd2, 1'b0, "clamp_hi");
    run_burst(16'd4, 16'd0, 16'd3, 1'b0, "clamp_silent");
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      run_burst(16'($urandom_range(0, 6)), 16'($urandom_range(0, 7)),
                16'($urandom_range(1, 5)), bit'(i % 2), "random");
  endtask

  task automatic test_free_run();
    period = 16'd5; high = 16'd1; num = 16'd0; start = 1'b1; stop = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 110; k++) begin
      total++;
      if ({out, busy, done, remaining} !== pack((k % 5) == 0, 1, 0, 16'd0)) begin
        bad++;
        $display("FAIL free_run cyc=%0d got=%h exp=%h", k + 1, {out, busy, done, remaining},
                 pack((k % 5) == 0, 1, 0, 16'd0));
      end
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({out, busy, done} !== 3'b000) begin
        bad++;
        $display("FAIL free_run_stop cyc=%0d got=%b exp=000", k, {out, busy, done});
      end
      tick();
    end
  endtask

  task automatic test_abort();
    period = 16'd4; high = 16'd2; num = 16'd10; start = 1'b1; stop = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      total++;
      if ({out, busy, done, remaining} !== pack((k % 4) < 2, 1, 0, 16'(10 - k / 4))) begin
        bad++;
        $display("FAIL abort_run cyc=%0d got=%h exp=%h", k + 1, {out, busy, done, remaining},
                 pack((k % 4) < 2, 1, 0, 16'(10 - k / 4)));
      end
      if (k == 8) stop = 1'b1;
      tick();
    end
    stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({out, busy, done, remaining} !== pack(0, 0, 0, 16'd8)) begin
        bad++;
        $display("FAIL abort_idle cyc=%0d got=%h exp=%h", k, {out, busy, done, remaining},
                 pack(0, 0, 0, 16'd8));
      end
      tick();
    end
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    total++;
    if ({out, busy, done, remaining} !== pack(0, 0, 0, 16'd8)) begin
      bad++;
      $display("FAIL start_stop_idle got=%h exp=%h", {out, busy, done, remaining}, pack(0, 0, 0, 16'd8));
    end
  endtask

  task automatic test_async_reset();
    period = 16'd6; high = 16'd3; num = 16'd4; start = 1'b1; stop = 1'b0;
    tick();
    start = 1'b0;
    repeat (7) tick();
    total++;
    if ({busy, remaining} !== {1'b1, 16'd3}) begin
      bad++;
      $display("FAIL async_pre got=%h exp=%h", {busy, remaining}, {1'b1, 16'd3});
    end
    #2;
    nreset = 1'b0;
    #1;
    total++;
    if ({out, busy, done, remaining} !== pack(0, 0, 0, 16'd0)) begin
      bad++;
      $display("FAIL async_drop got=%h exp=%h", {out, busy, done, remaining}, pack(0, 0, 0, 16'd0));
    end
    @(negedge clk);
    nreset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if ({out, busy, done, remaining} !== pack(0, 0, 0, 16'd0)) begin
        bad++;
        $display("FAIL async_release cyc=%0d got=%h exp=%h", k, {out, busy, done, remaining},
                 pack(0, 0, 0, 16'd0));
      end
    end
    run_burst(16'd2, 16'd1, 16'd2, 1'b0, "post_reset");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_clamps();
    test_random();
    test_free_run();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
